ecc_182_err_collect: RTL and testbench

- Stage directly downstream of the 182-bit ECC fault-detect checker on the FIFO read path.
- Registers the corrected read word with a valid/ready handshake toward the FIFO consumer.
- Counts single-bit, double-bit and checker-fault events, and captures the address/type of the first error.
- Raises a level interrupt that software clears via a clear pulse.

---
 rtl/ecc_182_err_collect.sv | 162 ++++++++++++++++
 tb/tb_ecc_182_err_collect.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_182_err_collect.sv
// ecc_182_err_collect
// Sits after the 182-bit ECC checker on the FIFO read path. It registers the
// corrected word toward the consumer with a valid/ready handshake. It also
// keeps saturating error statistics, records the first error seen, and drives
// a level interrupt that software clears with err_clr.
module ecc_182_err_collect #(
    parameter int                   DATA_WIDTH = 182,
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   CNT_WIDTH  = 16,
    parameter logic [CNT_WIDTH-1:0] SBIT_THR   = 16'd64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic                  in_ecc_fault,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_dbit_err,
    input  logic [2:0]            irq_en,
    input  logic                  err_clr,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [2:0]            err_sticky,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [2:0]            first_err_type,
    output logic                  sbit_thr_hit,
    output logic                  irq
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CAPT = 1'b1;

    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_dbit_err;
    logic [CNT_WIDTH-1:0]  r_sbit_cnt;
    logic [CNT_WIDTH-1:0]  r_dbit_cnt;
    logic [CNT_WIDTH-1:0]  r_fault_cnt;
    logic [2:0]            r_sticky;
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cap_addr;
    logic [2:0]            r_cap_type;
    logic                  r_thr_hit;
    logic                  r_irq;

    logic                  w_acc;
    logic [2:0]            w_flags;
    logic                  w_evt;
    logic [CNT_WIDTH-1:0]  w_sbit_nxt;
    logic [CNT_WIDTH-1:0]  w_dbit_nxt;
    logic [CNT_WIDTH-1:0]  w_fault_nxt;
    logic [2:0]            w_sticky_nxt;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_cap_addr_nxt;
    logic [2:0]            w_cap_type_nxt;

    // Clear takes effect first, then a same-cycle event adds on top of zero,
    // which is how "the event wins" over err_clr falls out naturally.
    function automatic logic [CNT_WIDTH-1:0] satStep(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 clr,
        input logic                 inc
    );
        logic [CNT_WIDTH-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != {CNT_WIDTH{1'b1}})) begin
            return base + 1'b1;
        end
        return base;
    endfunction

    assign in_rdy  = ~r_out_vld | out_rdy;
    assign w_acc   = in_vld & in_rdy;
    assign w_flags = {in_ecc_fault, in_dbit_err, in_sbit_err};
    assign w_evt   = w_acc & (|w_flags);

    // Next-state statistics, shared by the state registers and by the
    // registered threshold/irq outputs so those line up with the counters.
    always_comb begin
        w_sbit_nxt   = satStep(r_sbit_cnt,  err_clr, w_acc & in_sbit_err);
        w_dbit_nxt   = satStep(r_dbit_cnt,  err_clr, w_acc & in_dbit_err);
        w_fault_nxt  = satStep(r_fault_cnt, err_clr, w_acc & in_ecc_fault);
        w_sticky_nxt = (err_clr ? 3'b000 : r_sticky) | (w_acc ? w_flags : 3'b000);
    end

    // First-error capture: armed in IDLE, frozen in CAPT until err_clr.
    always_comb begin
        w_state_nxt    = r_state;
        w_cap_addr_nxt = r_cap_addr;
        w_cap_type_nxt = r_cap_type;
        if (err_clr) begin
            w_state_nxt    = S_IDLE;
            w_cap_addr_nxt = '0;
            w_cap_type_nxt = 3'b000;
        end
        if (w_evt && (err_clr || (r_state == S_IDLE))) begin
            w_state_nxt    = S_CAPT;
            w_cap_addr_nxt = in_addr;
            w_cap_type_nxt = w_flags;
        end
    end

    // Output word register: load on accept, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld      <= 1'b0;
            r_out_data     <= '0;
            r_out_dbit_err <= 1'b0;
        end else if (w_acc) begin
            r_out_vld      <= 1'b1;
            r_out_data     <= in_data;
            r_out_dbit_err <= in_dbit_err;
        end else if (out_rdy) begin
            r_out_vld      <= 1'b0;
        end
    end

    // Error statistics, capture FSM and the derived threshold/irq flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbit_cnt  <= '0;
            r_dbit_cnt  <= '0;
            r_fault_cnt <= '0;
            r_sticky    <= 3'b000;
            r_state     <= S_IDLE;
            r_cap_addr  <= '0;
            r_cap_type  <= 3'b000;
            r_thr_hit   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_sbit_cnt  <= w_sbit_nxt;
            r_dbit_cnt  <= w_dbit_nxt;
            r_fault_cnt <= w_fault_nxt;
            r_sticky    <= w_sticky_nxt;
            r_state     <= w_state_nxt;
            r_cap_addr  <= w_cap_addr_nxt;
            r_cap_type  <= w_cap_type_nxt;
            r_thr_hit   <= (w_sbit_nxt >= SBIT_THR);
            r_irq       <= |(w_sticky_nxt & irq_en);
        end
    end

    assign out_vld        = r_out_vld;
    assign out_data       = r_out_data;
    assign out_dbit_err   = r_out_dbit_err;
    assign sbit_cnt       = r_sbit_cnt;
    assign dbit_cnt       = r_dbit_cnt;
    assign fault_cnt      = r_fault_cnt;
    assign err_sticky     = r_sticky;
    assign first_err_addr = r_cap_addr;
    assign first_err_type = r_cap_type;
    assign sbit_thr_hit   = r_thr_hit;
    assign irq            = r_irq;

endmodule

// File: tb/tb_ecc_182_err_collect.sv
// Directed testbench for ecc_182_err_collect.
module tb_ecc_182_err_collect;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_vld;
    logic         in_rdy;
    logic [7:0]   in_addr;
    logic [181:0] in_data;
    logic         in_sbit_err;
    logic         in_dbit_err;
    logic         in_ecc_fault;
    logic         out_vld;
    logic         out_rdy;
    logic [181:0] out_data;
    logic         out_dbit_err;
    logic [2:0]   irq_en;
    logic         err_clr;
    logic [15:0]  sbit_cnt;
    logic [15:0]  dbit_cnt;
    logic [15:0]  fault_cnt;
    logic [2:0]   err_sticky;
    logic [7:0]   first_err_addr;
    logic [2:0]   first_err_type;
    logic         sbit_thr_hit;
    logic         irq;

    int nChecks = 0;
    int nFails  = 0;

    ecc_182_err_collect dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_ecc_fault(in_ecc_fault),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_dbit_err(out_dbit_err),
        .irq_en(irq_en), .err_clr(err_clr),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
        .err_sticky(err_sticky), .first_err_addr(first_err_addr), .first_err_type(first_err_type),
        .sbit_thr_hit(sbit_thr_hit), .irq(irq)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Address-dependent pattern so each word's data is distinguishable.
    function automatic logic [181:0] mkData(input logic [7:0] a);
        logic [181:0] d;
        for (int i = 0; i < 182; i++) begin
            d[i] = a[i % 8] ^ (i >= 91) ^ ((i % 3) == 0);
        end
        return d;
    endfunction

    task automatic applyStimulus(input logic vld, input logic [7:0] addr,
                                 input logic s, input logic d, input logic f,
                                 input logic clr);
        in_vld       = vld;
        in_addr      = addr;
        in_data      = mkData(addr);
        in_sbit_err  = s;
        in_dbit_err  = d;
        in_ecc_fault = f;
        err_clr      = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nChecks++; if (out_vld !== 1'b0) begin nFails++; $display("[TB] FAIL reset out_vld got %0b exp 0", out_vld); end
        nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("[TB] FAIL reset in_rdy got %0b exp 1", in_rdy); end
        nChecks++; if ({sbit_cnt, dbit_cnt, fault_cnt} !== 48'h0) begin nFails++; $display("[TB] FAIL reset counters got %h exp 0", {sbit_cnt, dbit_cnt, fault_cnt}); end
        nChecks++; if ({err_sticky, first_err_addr, first_err_type, sbit_thr_hit, irq} !== 16'h0) begin nFails++; $display("[TB] FAIL reset flags got %h exp 0", {err_sticky, first_err_addr, first_err_type, sbit_thr_hit, irq}); end
        nChecks++; if (out_data !== 182'h0) begin nFails++; $display("[TB] FAIL reset out_data got %h exp 0", out_data); end
    endtask

    task automatic test_clean();
        out_rdy = 1'b1;
        irq_en  = 3'b000;
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b1, 8'(a), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            nChecks++; if (out_vld !== 1'b1) begin nFails++; $display("[TB] FAIL clean out_vld[%0d] got %0b exp 1", a, out_vld); end
            nChecks++; if (out_data !== mkData(8'(a))) begin nFails++; $display("[TB] FAIL clean out_data[%0d] got %h exp %h", a, out_data, mkData(8'(a))); end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        nChecks++; if (out_vld !== 1'b0) begin nFails++; $display("[TB] FAIL clean drain out_vld got %0b exp 0", out_vld); end
        nChecks++; if ({sbit_cnt, dbit_cnt, fault_cnt} !== 48'h0) begin nFails++; $display("[TB] FAIL clean counters got %h exp 0", {sbit_cnt, dbit_cnt, fault_cnt}); end
        nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL clean irq got %0b exp 0", irq); end
    endtask

    task automatic test_capture();
        irq_en = 3'b001;
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        nChecks++; if (sbit_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL capt sbit_cnt got %0d exp 1", sbit_cnt); end
        nChecks++; if (err_sticky !== 3'b001) begin nFails++; $display("[TB] FAIL capt sticky got %b exp 001", err_sticky); end
        nChecks++; if (first_err_addr !== 8'h12) begin nFails++; $display("[TB] FAIL capt addr got %h exp 12", first_err_addr); end
        nChecks++; if (first_err_type !== 3'b001) begin nFails++; $display("[TB] FAIL capt type got %b exp 001", first_err_type); end
        nChecks++; if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL capt irq got %0b exp 1", irq); end
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        nChecks++; if (dbit_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL capt2 dbit_cnt got %0d exp 1", dbit_cnt); end
        nChecks++; if (out_dbit_err !== 1'b1) begin nFails++; $display("[TB] FAIL capt2 out_dbit_err got %0b exp 1", out_dbit_err); end
        nChecks++; if ({first_err_addr, first_err_type} !== {8'h12, 3'b001}) begin nFails++; $display("[TB] FAIL capt2 hold got %h/%b exp 12/001", first_err_addr, first_err_type); end
        nChecks++; if (err_sticky !== 3'b011) begin nFails++; $display("[TB] FAIL capt2 sticky got %b exp 011", err_sticky); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        err_clr = 1'b0;
        nChecks++; if ({sbit_cnt, dbit_cnt, fault_cnt} !== 48'h0) begin nFails++; $display("[TB] FAIL clr counters got %h exp 0", {sbit_cnt, dbit_cnt, fault_cnt}); end
        nChecks++; if ({err_sticky, first_err_addr, first_err_type, irq} !== 15'h0) begin nFails++; $display("[TB] FAIL clr flags got %h exp 0", {err_sticky, first_err_addr, first_err_type, irq}); end
    endtask

    task automatic test_irq_en();
        irq_en = 3'b010;
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        nChecks++; if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL irqen on got %0b exp 1", irq); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        irq_en = 3'b101;
        step();
        nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL irqen masked got %0b exp 0", irq); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b0;
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        nChecks++; if (out_vld !== 1'b1) begin nFails++; $display("[TB] FAIL bp out_vld got %0b exp 1", out_vld); end
        nChecks++; if (in_rdy !== 1'b0) begin nFails++; $display("[TB] FAIL bp in_rdy got %0b exp 0", in_rdy); end
        applyStimulus(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step();
            nChecks++; if (out_data !== mkData(8'h30)) begin nFails++; $display("[TB] FAIL bp hold data[%0d] got %h exp %h", c, out_data, mkData(8'h30)); end
            nChecks++; if (sbit_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL bp no double count[%0d] got %0d exp 1", c, sbit_cnt); end
        end
        out_rdy = 1'b1;
        #1;
        nChecks++; if (in_rdy !== 1'b1) begin nFails++; $display("[TB] FAIL bp release in_rdy got %0b exp 1", in_rdy); end
        step();
        nChecks++; if (out_data !== mkData(8'h31)) begin nFails++; $display("[TB] FAIL bp second word got %h exp %h", out_data, mkData(8'h31)); end
        nChecks++; if (sbit_cnt !== 16'd2) begin nFails++; $display("[TB] FAIL bp sbit_cnt got %0d exp 2", sbit_cnt); end
        nChecks++; if (first_err_addr !== 8'h30) begin nFails++; $display("[TB] FAIL bp capture got %h exp 30", first_err_addr); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        nChecks++; if (out_vld !== 1'b0) begin nFails++; $display("[TB] FAIL bp drained got %0b exp 0", out_vld); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_saturation();
        out_rdy = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 65536; i++) begin
            step();
            if (i == 63) begin
                nChecks++; if ({sbit_cnt, sbit_thr_hit} !== {16'd63, 1'b0}) begin nFails++; $display("[TB] FAIL sat thr63 got %0d/%0b exp 63/0", sbit_cnt, sbit_thr_hit); end
            end
            if (i == 64) begin
                nChecks++; if ({sbit_cnt, sbit_thr_hit} !== {16'd64, 1'b1}) begin nFails++; $display("[TB] FAIL sat thr64 got %0d/%0b exp 64/1", sbit_cnt, sbit_thr_hit); end
            end
            if (i == 65535) begin
                nChecks++; if (sbit_cnt !== 16'hFFFF) begin nFails++; $display("[TB] FAIL sat max got %h exp ffff", sbit_cnt); end
            end
        end
        nChecks++; if ({sbit_cnt, sbit_thr_hit} !== {16'hFFFF, 1'b1}) begin nFails++; $display("[TB] FAIL sat hold got %h/%0b exp ffff/1", sbit_cnt, sbit_thr_hit); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_clr_with_event();
        irq_en = 3'b111;
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if ({fault_cnt, dbit_cnt, sbit_cnt} !== {16'd1, 16'd1, 16'd0}) begin nFails++; $display("[TB] FAIL clrevt counters got %h exp 000100010000", {fault_cnt, dbit_cnt, sbit_cnt}); end
        nChecks++; if (err_sticky !== 3'b110) begin nFails++; $display("[TB] FAIL clrevt sticky got %b exp 110", err_sticky); end
        nChecks++; if ({first_err_addr, first_err_type} !== {8'h05, 3'b110}) begin nFails++; $display("[TB] FAIL clrevt capture got %h/%b exp 05/110", first_err_addr, first_err_type); end
        nChecks++; if ({sbit_thr_hit, irq} !== 2'b01) begin nFails++; $display("[TB] FAIL clrevt thr/irq got %b exp 01", {sbit_thr_hit, irq}); end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        out_rdy = 1'b0;
        nChecks++; if ({out_vld, sbit_cnt} !== {1'b1, 16'd1}) begin nFails++; $display("[TB] FAIL arst pre got %h exp 10001", {out_vld, sbit_cnt}); end
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if ({out_vld, irq, err_sticky, sbit_thr_hit} !== 6'h0) begin nFails++; $display("[TB] FAIL arst flags got %b exp 0", {out_vld, irq, err_sticky, sbit_thr_hit}); end
        nChecks++; if ({sbit_cnt, dbit_cnt, fault_cnt, first_err_addr, first_err_type} !== 59'h0) begin nFails++; $display("[TB] FAIL arst state got %h exp 0", {sbit_cnt, dbit_cnt, fault_cnt, first_err_addr, first_err_type}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        nChecks++; if ({in_rdy, out_vld} !== 2'b10) begin nFails++; $display("[TB] FAIL arst release got %b exp 10", {in_rdy, out_vld}); end
    endtask

    // Sequence the scenarios, then print the summary.
    initial begin
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        irq_en  = 3'b000;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_clean();
        test_capture();
        test_irq_en();
        test_back_to_back();
        test_saturation();
        test_clr_with_event();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
        $finish;
    end

endmodule
